// File: rtl/ntr_pkg.sv
// Shared opcode, state and field definitions for the NTR command sequencer.
package ntr_pkg;

  localparam logic [7:0] OP_LED    = 8'hFF;
  localparam logic [7:0] OP_READ   = 8'hB7;
  localparam logic [7:0] OP_CHIPID = 8'h90;
  localparam logic [7:0] OP_DUMMY  = 8'h9F;

  // Field positions inside the 64-bit command word
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 8;
  localparam int ADDR_LSB   = 16;
  localparam int ADDR_W     = 32;
  localparam int LED_BIT    = 56;

  localparam logic [3:0] ERR_MAX = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_LED    = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  function automatic logic is_resp_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_CHIPID);
  endfunction

endpackage

// File: rtl/ntr_cmd_ctrl_if.sv
// Command capture and response handshake bundle between the NTR side and the sequencer.
interface ntr_cmd_ctrl_if;
  import ntr_pkg::*;

  logic [63:0]       cmd_in;
  logic              cmd_ready;
  logic              resp_ack;
  logic              resp_valid;
  logic [7:0]        resp_opcode;
  logic [ADDR_W-1:0] resp_addr;

  // master: receiver and response engine side; slave: the sequencer
  modport master (
    output cmd_in, cmd_ready, resp_ack,
    input  resp_valid, resp_opcode, resp_addr
  );

  modport slave (
    input  cmd_in, cmd_ready, resp_ack,
    output resp_valid, resp_opcode, resp_addr
  );

endinterface

// File: rtl/ntr_cmd_fifo.sv
// Circular command queue; head word is visible on pop_data whenever not empty.
module ntr_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign pop_data = mem[rd_ptr_reg];

  // A full queue still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (PTR_W+1)'(1);
        2'b01:   level_reg <= level_reg - (PTR_W+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/ntr_cmd_ctrl.sv
// NTR command sequencer: synchronises the receiver strobe, queues commands and
// dispatches them to the LED register, the response engine or the error counter.
module ntr_cmd_ctrl
  import ntr_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int PTR_W       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  ntr_cmd_ctrl_if.slave      bus,
  output logic               led,
  output logic [PTR_W:0]     q_level,
  output logic               overflow,
  output logic [3:0]         err_count
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   edge_reg;
  logic                   push;

  logic [63:0]            fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;

  state_e                 state_reg;
  logic [63:0]            cmd_reg;
  logic [7:0]             cur_op;
  logic                   led_reg;
  logic                   overflow_reg;
  logic [3:0]             err_count_reg;
  logic                   resp_valid_reg;
  logic [7:0]             resp_opcode_reg;
  logic [ADDR_W-1:0]      resp_addr_reg;
  logic                   unused_cmd_bits;

  // cmd_ready is asynchronous to clk; only the last stage feeds logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg[0] <= 1'b0;
    end else begin
      sync_reg[0] <= bus.cmd_ready;
    end
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_reg <= 1'b0;
    end else begin
      edge_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign push     = sync_reg[SYNC_STAGES-1] && !edge_reg;
  assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;

  ntr_cmd_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.cmd_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (q_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (push && fifo_full && !fifo_pop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign cur_op = cmd_reg[OPCODE_LSB +: OPCODE_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cmd_reg         <= '0;
      led_reg         <= 1'b0;
      err_count_reg   <= '0;
      resp_valid_reg  <= 1'b0;
      resp_opcode_reg <= '0;
      resp_addr_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cmd_reg   <= fifo_head;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (cur_op == OP_LED) begin
            state_reg <= ST_LED;
          end else if (is_resp_op(cur_op)) begin
            resp_valid_reg  <= 1'b1;
            resp_opcode_reg <= cur_op;
            resp_addr_reg   <= cmd_reg[ADDR_LSB +: ADDR_W];
            state_reg       <= ST_RESP;
          end else if (cur_op == OP_DUMMY) begin
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_ERR;
          end
        end
        ST_LED: begin
          led_reg   <= cmd_reg[LED_BIT];
          state_reg <= ST_IDLE;
        end
        ST_RESP: begin
          if (bus.resp_ack) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (err_count_reg != ERR_MAX) begin
            err_count_reg <= err_count_reg + 4'd1;
          end
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Bytes of the command word that no opcode currently uses
  assign unused_cmd_bits = ^{cmd_reg[15:8], cmd_reg[55:48], cmd_reg[63:57]};

  assign led             = led_reg;
  assign overflow        = overflow_reg;
  assign err_count       = err_count_reg;
  assign bus.resp_valid  = resp_valid_reg;
  assign bus.resp_opcode = resp_opcode_reg;
  assign bus.resp_addr   = resp_addr_reg;

endmodule
